// File: rtl/mem_router.sv
// mem_router: routes the core's single memory master port to NUM_SLAVES
// peripherals by address region. One transaction is in flight at a time;
// unmapped addresses complete immediately with an access-fault response.
// Optional feature: define MEM_ROUTER_TIMEOUT_EN to add a wait-state limit
// that turns an unresponsive slave into an error response.
module mem_router #(
  parameter int                   NUM_SLAVES     = 5,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDR  = {32'h80000000, 32'h03000000,
                                                    32'h02000000, 32'h01000000,
                                                    32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0] TOP_ADDR   = {32'h90000000, 32'h03005000,
                                                    32'h0200C000, 32'h01000004,
                                                    32'h00000080},
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  // master side
  input  logic                     m_valid,
  input  logic                     m_instr,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wstrb,
  output logic [31:0]              m_rdata,
  output logic                     m_ready,
  output logic                     m_error,
  output logic                     busy,
  // slave side
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic                     s_instr,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ready
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  // Elaboration-time guard against parameter sets the decoder cannot serve.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_router: NUM_SLAVES must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel;

  logic             dec_hit;
  logic [SEL_W-1:0] dec_idx;
  logic             sel_ready;
  logic [31:0]      sel_rdata;

`ifdef MEM_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Region decode: scan downwards so that the lowest matching index wins.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (m_addr >= BASE_ADDR[i*32 +: 32] && m_addr < TOP_ADDR[i*32 +: 32]) begin
        dec_hit = 1'b1;
        dec_idx = SEL_W'(i);
      end
    end
  end

  // Response lane of the currently selected slave; other lanes are ignored.
  always_comb begin
    sel_ready = s_ready[sel];
    sel_rdata = s_rdata[int'(sel)*32 +: 32];
  end

  // Transaction FSM with registered master/slave outputs.
  // NOTE: state and outputs here use non-blocking assignments so that every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sel      <= '0;
      s_valid  <= '0;
      s_instr  <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
      m_rdata  <= '0;
      m_ready  <= 1'b0;
      m_error  <= 1'b0;
      busy     <= 1'b0;
`ifdef MEM_ROUTER_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      // Pulsed outputs default low; the branches below raise them for one cycle.
      s_valid <= '0;
      m_ready <= 1'b0;
      m_error <= 1'b0;

      unique case (state)
        IDLE: begin
          if (m_valid) begin
            s_instr <= m_instr;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
            sel     <= dec_idx;
            busy    <= 1'b1;
            if (dec_hit) begin
              state            <= REQ;
              s_valid[dec_idx] <= 1'b1;
            end else begin
              state   <= ERR;
              m_ready <= 1'b1;
              m_error <= 1'b1;
              m_rdata <= '0;
            end
          end
        end

        REQ: begin
          // A slave that answers while its request is still visible is accepted.
          if (sel_ready) begin
            state   <= RESP;
            m_ready <= 1'b1;
            m_rdata <= sel_rdata;
          end else begin
            state <= WAIT;
`ifdef MEM_ROUTER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        WAIT: begin
          if (sel_ready) begin
            state   <= RESP;
            m_ready <= 1'b1;
            m_rdata <= sel_rdata;
          end
`ifdef MEM_ROUTER_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            state   <= ERR;
            m_ready <= 1'b1;
            m_error <= 1'b1;
            m_rdata <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        RESP, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_router.sv
// Self-checking bench for mem_router: boundary table, hand-written corner
// sequences and randomized transactions against a first-match region model.
// Build with MEM_ROUTER_TIMEOUT_EN defined to exercise the timeout path.
`timescale 1ns/1ps
module tb_mem_router;

  localparam int NS = 5;
  localparam logic [NS*32-1:0] BASE = {32'h80000000, 32'h03000000, 32'h02000000,
                                       32'h01000000, 32'h00000000};
  localparam logic [NS*32-1:0] TOP  = {32'h90000000, 32'h03005000, 32'h0200C000,
                                       32'h01000004, 32'h00000080};
  localparam int TO = 8;

  logic           clock;
  logic           reset;
  logic           m_valid;
  logic           m_instr;
  logic [31:0]    m_addr;
  logic [31:0]    m_wdata;
  logic [3:0]     m_wstrb;
  logic [31:0]    m_rdata;
  logic           m_ready;
  logic           m_error;
  logic           busy;
  logic [NS-1:0]  s_valid;
  logic           s_instr;
  logic [31:0]    s_addr;
  logic [31:0]    s_wdata;
  logic [3:0]     s_wstrb;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0]  s_ready;

  mem_router #(
    .NUM_SLAVES    (NS),
    .BASE_ADDR     (BASE),
    .TOP_ADDR      (TOP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .m_valid(m_valid),
    .m_instr(m_instr),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_wstrb(m_wstrb),
    .m_rdata(m_rdata),
    .m_ready(m_ready),
    .m_error(m_error),
    .busy   (busy),
    .s_valid(s_valid),
    .s_instr(s_instr),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_wstrb(s_wstrb),
    .s_rdata(s_rdata),
    .s_ready(s_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference memory map, written directly from the region table.
  logic [31:0] reg_base [NS] = '{32'h00000000, 32'h01000000, 32'h02000000,
                                 32'h03000000, 32'h80000000};
  logic [31:0] reg_top  [NS] = '{32'h00000080, 32'h01000004, 32'h0200C000,
                                 32'h03005000, 32'h90000000};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // First matching region in index order, or -1 for an unmapped address.
  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (a >= reg_base[i] && a < reg_top[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_rdata();
    for (int j = 0; j < NS; j++) s_rdata[j*32 +: 32] = $urandom;
  endtask

  // One complete transaction. Entered and left just after a rising edge,
  // with the router idle. delay = number of cycles after the request cycle
  // before the selected slave answers (0 = answer during the request cycle).
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr,
                         input int delay, input logic [31:0] rdata,
                         input int exp_idx, input string tag);
    logic [NS-1:0] onehot;
    logic [NS-1:0] spur;
    m_valid = 1'b1;
    m_addr  = addr;
    m_wdata = wdata;
    m_wstrb = wstrb;
    m_instr = instr;
    tick();
    m_valid = 1'b0;
    m_addr  = $urandom;
    if (exp_idx < 0) begin
      @(negedge clock);
      check({tag, " miss m_ready"}, 32'(m_ready), 32'd1);
      check({tag, " miss m_error"}, 32'(m_error), 32'd1);
      check({tag, " miss m_rdata"}, m_rdata, 32'd0);
      check({tag, " miss s_valid"}, 32'(s_valid), 32'd0);
      tick();
      @(negedge clock);
      check({tag, " miss idle"}, {30'd0, m_ready, busy}, 32'd0);
      tick();
    end else begin
      onehot = '0;
      onehot[exp_idx] = 1'b1;
      for (int k = 0; k <= delay; k++) begin
        spur = NS'($urandom) & ~onehot;
        randomize_rdata();
        s_ready = (k == delay) ? (spur | onehot) : spur;
        if (k == delay) s_rdata[exp_idx*32 +: 32] = rdata;
        @(negedge clock);
        if (k == 0) begin
          check({tag, " s_valid"}, 32'(s_valid), 32'(onehot));
          check({tag, " s_addr"},  s_addr, addr);
          check({tag, " s_wdata"}, s_wdata, wdata);
          check({tag, " s_wstrb/instr"}, {27'd0, s_wstrb, s_instr}, {27'd0, wstrb, instr});
        end else begin
          check({tag, " s_valid quiet"}, 32'(s_valid), 32'd0);
        end
        check({tag, " wait m_ready/busy"}, {30'd0, m_ready, busy}, 32'd1);
        tick();
      end
      s_ready = '0;
      randomize_rdata();
      @(negedge clock);
      check({tag, " resp m_ready/m_error/busy"}, {29'd0, m_ready, m_error, busy}, 32'b101);
      check({tag, " resp m_rdata"}, m_rdata, rdata);
      tick();
      @(negedge clock);
      check({tag, " done m_ready/busy"}, {30'd0, m_ready, busy}, 32'd0);
      check({tag, " m_rdata hold"}, m_rdata, rdata);
      tick();
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    int          delay;
    logic [31:0] rdata;
    int          exp_idx;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          r;
    int          n;
    logic        saw_ready;

    reset   = 1'b0;
    m_valid = 1'b0;
    m_instr = 1'b0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    m_wstrb = 4'h0;
    s_rdata = '0;
    s_ready = '0;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset pulses", {29'd0, m_ready, m_error, busy}, 32'd0);
    check("reset s_valid", 32'(s_valid), 32'd0);
    check("reset m_rdata", m_rdata, 32'd0);
    check("reset s_addr/wdata", s_addr | s_wdata | {27'd0, s_wstrb, s_instr}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick();

    // Boundary table: region edges, exclusive tops, unmapped space.
    vecs.push_back('{32'h00000040, 32'h00000000, 4'h0, 1'b0, 1, 32'hDEADBEEF, 0});
    vecs.push_back('{32'h01000004, 32'h00000000, 4'h0, 1'b0, 0, 32'h0,        -1});
    vecs.push_back('{32'h02004000, 32'h12345678, 4'hF, 1'b0, 3, 32'h0BADF00D, 2});
    vecs.push_back('{32'h00000000, 32'h0,        4'h0, 1'b1, 0, 32'h00000013, 0});
    vecs.push_back('{32'h0000007F, 32'hA5A5A5A5, 4'h1, 1'b0, 2, 32'h11111111, 0});
    vecs.push_back('{32'h00000080, 32'h0,        4'h0, 1'b0, 0, 32'h0,        -1});
    vecs.push_back('{32'h01000000, 32'h00000041, 4'h1, 1'b0, 1, 32'h22222222, 1});
    vecs.push_back('{32'h01000003, 32'h0,        4'h0, 1'b0, 4, 32'h33333333, 1});
    vecs.push_back('{32'h0200BFFC, 32'h0,        4'h0, 1'b0, 1, 32'h44444444, 2});
    vecs.push_back('{32'h0200C000, 32'h0,        4'h0, 1'b0, 0, 32'h0,        -1});
    vecs.push_back('{32'h03000000, 32'h0,        4'h0, 1'b0, 2, 32'h55555555, 3});
    vecs.push_back('{32'h03004FFF, 32'hFFFF0000, 4'hC, 1'b0, 0, 32'h66666666, 3});
    vecs.push_back('{32'h03005000, 32'h0,        4'h0, 1'b0, 0, 32'h0,        -1});
    vecs.push_back('{32'h80000000, 32'h0,        4'h0, 1'b1, 1, 32'h77777777, 4});
    vecs.push_back('{32'h8FFFFFFC, 32'h0,        4'h0, 1'b0, 3, 32'h88888888, 4});
    vecs.push_back('{32'h90000000, 32'h0,        4'h0, 1'b0, 0, 32'h0,        -1});
    vecs.push_back('{32'hFFFFFFFF, 32'h0,        4'h0, 1'b0, 0, 32'h0,        -1});

    foreach (vecs[i])
      run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].instr,
              vecs[i].delay, vecs[i].rdata, vecs[i].exp_idx, $sformatf("vec%0d", i));

    // Second request during a BRAM wait is ignored.
    m_valid = 1'b1; m_addr = 32'h00000040; m_wdata = 32'h0; m_wstrb = 4'h0; m_instr = 1'b0;
    tick();
    m_valid = 1'b0;
    tick();                                   // now in WAIT
    m_valid = 1'b1; m_addr = 32'h03000000; m_wdata = 32'hFEEDFACE; m_wstrb = 4'hF;
    tick();
    m_valid = 1'b0;
    @(negedge clock);
    check("overlap s_valid", 32'(s_valid), 32'd0);
    check("overlap busy", 32'(busy), 32'd1);
    check("overlap s_addr kept", s_addr, 32'h00000040);
    tick();
    @(negedge clock);
    check("overlap s_valid later", 32'(s_valid), 32'd0);
    s_ready = 5'b00001;
    s_rdata[0 +: 32] = 32'hC0FFEE01;
    tick();
    s_ready = '0;
    @(negedge clock);
    check("overlap resp", {29'd0, m_ready, m_error, busy}, 32'b101);
    check("overlap rdata", m_rdata, 32'hC0FFEE01);
    tick();
    tick();

    // Asynchronous reset during WAIT aborts the transaction.
    m_valid = 1'b1; m_addr = 32'h01000000; m_wdata = 32'h0000ABCD; m_wstrb = 4'h3;
    tick();
    m_valid = 1'b0;
    tick();                                   // now in WAIT
    reset = 1'b0;
    #1;
    check("async reset pulses", {29'd0, m_ready, m_error, busy}, 32'd0);
    check("async reset s_addr", s_addr, 32'd0);
    check("async reset s_wdata", s_wdata, 32'd0);
    check("async reset m_rdata", m_rdata, 32'd0);
    s_ready = 5'b00010;
    tick();
    s_ready = '0;
    reset = 1'b1;
    @(negedge clock);
    check("post reset no m_ready", {30'd0, m_ready, busy}, 32'd0);
    tick();
    run_txn(32'h00000000, 32'h0, 4'h0, 1'b0, 1, 32'h600D600D, 0, "after reset");

`ifdef MEM_ROUTER_TIMEOUT_EN
    // Silent slave: error after TO wait cycles.
    m_valid = 1'b1; m_addr = 32'h80000000; m_wstrb = 4'h0;
    tick();
    m_valid = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      if (m_ready) break;
      tick();
      n++;
    end
    check("timeout latency", n, TO + 1);
    check("timeout m_error", 32'(m_error), 32'd1);
    check("timeout m_rdata", m_rdata, 32'd0);
    tick();
    s_ready = 5'b10000;                       // late answer is ignored
    @(negedge clock);
    check("late ready ignored", 32'(m_ready), 32'd0);
    tick();
    s_ready = '0;
    @(negedge clock);
    check("late ready ignored 2", {30'd0, m_ready, busy}, 32'd0);
    tick();

    // Answer on the expiry cycle wins.
    m_valid = 1'b1; m_addr = 32'h80000000;
    tick();
    m_valid = 1'b0;
    repeat (TO) tick();
    s_ready = 5'b10000;
    s_rdata[4*32 +: 32] = 32'hCAFEF00D;
    @(negedge clock);
    check("expiry cycle m_ready", 32'(m_ready), 32'd0);
    tick();
    s_ready = '0;
    @(negedge clock);
    check("expiry ready wins", {30'd0, m_ready, m_error}, 32'b10);
    check("expiry rdata", m_rdata, 32'hCAFEF00D);
    tick();
    tick();
`else
    // Without the timeout, a silent slave keeps the router waiting.
    m_valid = 1'b1; m_addr = 32'h80000000; m_wstrb = 4'h0;
    tick();
    m_valid = 1'b0;
    saw_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      saw_ready |= m_ready;
      tick();
    end
    check("silent no m_ready", 32'(saw_ready), 32'd0);
    check("silent busy", 32'(busy), 32'd1);
    s_ready = 5'b10000;
    s_rdata[4*32 +: 32] = 32'hCAFEF00D;
    tick();
    s_ready = '0;
    @(negedge clock);
    check("silent late resp", {29'd0, m_ready, m_error, busy}, 32'b101);
    check("silent late rdata", m_rdata, 32'hCAFEF00D);
    tick();
    tick();
`endif

    // Randomized traffic against the region model.
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, NS);
      if (r < NS) a = reg_base[r] + $urandom_range(0, reg_top[r] - reg_base[r] - 1);
      else        a = $urandom;
      run_txn(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 4),
              $urandom, ref_decode(a), $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
